lenet_argmax_readout: RTL and testbench

- Sequential output stage placed directly downstream of the c5 fully-connected stage.
- Captures c5's packed vector of OUTLEN signed 64-bit class scores on a start strobe.
- Scans the scores one per cycle and reports the winning class index (8-bit, matching the CPU-side result register) plus its score, using a done/ack handshake.
- Holds the captured scores in a buffer that the CPU reads back in 32-bit words for storage in CPU RAM.

---
 rtl/lenet_argmax_readout.sv | 182 ++++++++++++++++++
 tb/tb_lenet_argmax_readout.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_argmax_readout.sv
// -----------------------------------------------------------------------------
// lenet_argmax_readout
//
// Output stage behind the c5 fully-connected layer. On a start strobe it
// captures every class score in one cycle. It then walks the captured scores
// one per cycle and keeps a running signed maximum. When the walk finishes it
// publishes the winning class index and that score, and holds done_o until
// the consumer acknowledges. The captured scores stay in a buffer so the CPU
// can read them back as 32-bit words.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      capture scores_i and begin the scan (accepted only in IDLE)
//   scores_i     packed c5 scores, score k at [k*SCORE_W +: SCORE_W], signed
//   busy_o       high while the scan is running
//   done_o       result valid, held until ack_i is sampled
//   ack_i        consumer acknowledge of done_o
//   class_o      index of the maximum score, zero-extended to 8 bits
//   max_score_o  value of the maximum score
//   rd_addr_i    readback word address
//   rd_data_o    registered readback word (one-cycle latency)
// -----------------------------------------------------------------------------
module lenet_argmax_readout #(
  parameter int OUTLEN  = 10,
  parameter int SCORE_W = 64,
  parameter int RD_W    = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [OUTLEN*SCORE_W-1:0] scores_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic                      ack_i,
  output logic [7:0]                class_o,
  output logic [SCORE_W-1:0]        max_score_o,
  input  logic [ADDR_W-1:0]         rd_addr_i,
  output logic [RD_W-1:0]           rd_data_o
);

  localparam int CNT_W = (OUTLEN > 1) ? $clog2(OUTLEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUTLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  state_e                           state_q, state_d;
  logic [OUTLEN-1:0][SCORE_W-1:0]   score_buf_q, score_buf_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [SCORE_W-1:0]               run_max_q, run_max_d;
  logic [CNT_W-1:0]                 run_idx_q, run_idx_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic [7:0]                       class_q, class_d;
  logic [SCORE_W-1:0]               max_score_q, max_score_d;
  logic [RD_W-1:0]                  rd_data_q, rd_data_d;

  logic [SCORE_W-1:0]               cur_score;
  logic                             take_new;
  logic [SCORE_W-1:0]               new_max;
  logic [CNT_W-1:0]                 new_idx;

  // Next-state logic for the scan FSM, the capture buffer and the readback port.
  always_comb begin
    state_d     = state_q;
    score_buf_d = score_buf_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    class_d     = class_q;
    max_score_d = max_score_q;

    // Select the score under the counter. A decode loop keeps the index
    // inside the OUTLEN entries even though the counter could encode more.
    cur_score = '0;
    for (int k = 0; k < OUTLEN; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        cur_score = score_buf_q[k];
      end
    end

    // The compare is strict, so on a tie the earlier (lower) index is kept.
    take_new = $signed(cur_score) > $signed(run_max_q);
    new_max  = take_new ? cur_score : run_max_q;
    new_idx  = take_new ? cnt_q     : run_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          score_buf_d = scores_i;
          run_max_d   = scores_i[SCORE_W-1:0];
          run_idx_d   = '0;
          cnt_d       = CNT_W'(1);
          busy_d      = 1'b1;
          state_d     = ST_SCAN;
        end
      end

      ST_SCAN: begin
        run_max_d = new_max;
        run_idx_d = new_idx;
        if (cnt_q == LAST_IDX) begin
          // The result is published only here, so class_o and max_score_o
          // never show a partial scan.
          class_d     = 8'(new_idx);
          max_score_d = new_max;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cnt_d       = '0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // A start arriving with the ack is dropped; a new start must come in IDLE.
        if (ack_i) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    // Word 2k is the low half of score k and word 2k+1 the high half.
    // Addresses past the buffer read as zero.
    rd_data_d = '0;
    for (int w = 0; w < 2 * OUTLEN; w++) begin
      if (rd_addr_i == ADDR_W'(w)) begin
        rd_data_d = score_buf_q[w / 2][(w % 2) * RD_W +: RD_W];
      end
    end
  end

  // State and output registers. Reset clears everything, including the buffer,
  // so an interrupted scan leaves no trace.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      score_buf_q <= '0;
      cnt_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      class_q     <= '0;
      max_score_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      score_buf_q <= score_buf_d;
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      class_q     <= class_d;
      max_score_q <= max_score_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign class_o     = class_q;
  assign max_score_o = max_score_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_lenet_argmax_readout.sv
// -----------------------------------------------------------------------------
// tb_lenet_argmax_readout
//
// Self-checking bench for lenet_argmax_readout. A table of directed score
// vectors with hand-derived results is applied first. After that come the
// multi-cycle corner sequences: a start during the scan, start together with
// ack, and an asynchronous reset during the scan. Random vectors are then
// checked against a reference argmax. The reference finds the signed maximum
// first and then takes the first index that holds that value.
// -----------------------------------------------------------------------------
module tb_lenet_argmax_readout;

  localparam int OUTLEN  = 10;
  localparam int SCORE_W = 64;
  localparam int RD_W    = 32;
  localparam int ADDR_W  = 5;
  localparam int VW      = OUTLEN * SCORE_W;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic [VW-1:0]     scores_i;
  logic              busy_o;
  logic              done_o;
  logic              ack_i;
  logic [7:0]        class_o;
  logic [SCORE_W-1:0] max_score_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [RD_W-1:0]   rd_data_o;

  int tests_run    = 0;
  int tests_failed = 0;

  lenet_argmax_readout #(
    .OUTLEN (OUTLEN),
    .SCORE_W(SCORE_W),
    .RD_W   (RD_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .scores_i   (scores_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ack_i      (ack_i),
    .class_o    (class_o),
    .max_score_o(max_score_o),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [VW-1:0] scores;
    logic [7:0]    exp_class;
    logic [63:0]   exp_max;
  } vec_t;

  vec_t tbl[6];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference argmax: signed maximum first, then the lowest index holding it.
  function automatic void refArgmax(input logic [VW-1:0] sc, output logic [7:0] c,
                                    output logic [63:0] m);
    longint mx;
    longint v;
    mx = sc[63:0];
    for (int k = 1; k < OUTLEN; k++) begin
      v = sc[k*SCORE_W +: SCORE_W];
      if (v > mx) mx = v;
    end
    c = 8'd0;
    for (int k = OUTLEN - 1; k >= 0; k--) begin
      v = sc[k*SCORE_W +: SCORE_W];
      if (v == mx) c = 8'(k);
    end
    m = mx;
  endfunction

  // Readback words are consecutive 32-bit slices of the captured vector.
  function automatic logic [31:0] modelWord(input logic [VW-1:0] sc, input int a);
    if (a >= 2 * OUTLEN) return 32'd0;
    return sc[a*RD_W +: RD_W];
  endfunction

  // Pulse start with the given scores. Return the number of cycles until
  // done_o rises and the number of cycles busy_o was high.
  task automatic applyStimulus(input logic [VW-1:0] sc, output int lat, output int busy_cnt);
    @(negedge clk_i);
    scores_i = sc;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i  = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done_o && lat < 40) begin
      if (busy_o) busy_cnt++;
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic runAndCheck(input string name, input logic [VW-1:0] sc,
                             input logic [7:0] ec, input logic [63:0] em);
    int lat;
    int bc;
    applyStimulus(sc, lat, bc);
    checkOutput($sformatf("%s latency", name), 64'(lat), 64'd9);
    checkOutput($sformatf("%s busy cycles", name), 64'(bc), 64'd9);
    checkOutput($sformatf("%s busy at done", name), 64'(busy_o), 64'd0);
    checkOutput($sformatf("%s class", name), 64'(class_o), 64'(ec));
    checkOutput($sformatf("%s max", name), max_score_o, em);
  endtask

  task automatic ackResult(input string name, input logic [7:0] ec, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      checkOutput($sformatf("%s done held %0d", name, i), 64'(done_o), 64'd1);
    end
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    checkOutput($sformatf("%s done after ack", name), 64'(done_o), 64'd0);
    checkOutput($sformatf("%s class kept", name), 64'(class_o), 64'(ec));
  endtask

  task automatic checkReadback(input string name, input logic [VW-1:0] sc);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk_i);
      rd_addr_i = ADDR_W'(a);
      @(negedge clk_i);
      checkOutput($sformatf("%s rd[%0d]", name, a), 64'(rd_data_o), 64'(modelWord(sc, a)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [VW-1:0] sc;
    logic [VW-1:0] sc_a;
    logic [VW-1:0] sc_b;
    logic [7:0]    ec;
    logic [63:0]   em;
    int            lat;
    int            bad;

    // Directed vectors with hand-derived results.
    for (int k = 0; k < OUTLEN; k++) sc[k*64 +: 64] = 64'(k * 10);
    tbl[0] = '{scores: sc, exp_class: 8'd9, exp_max: 64'd90};
    for (int k = 0; k < OUTLEN; k++) sc[k*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFB;
    sc[3*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFE;
    sc[7*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFE;
    tbl[1] = '{scores: sc, exp_class: 8'd3, exp_max: 64'hFFFF_FFFF_FFFF_FFFE};
    for (int k = 0; k < OUTLEN; k++) sc[k*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    tbl[2] = '{scores: sc, exp_class: 8'd0, exp_max: 64'hFFFF_FFFF_FFFF_FFFF};
    sc = '0;
    sc[4*64 +: 64] = 64'h0123_4567_89AB_CDEF;
    tbl[3] = '{scores: sc, exp_class: 8'd4, exp_max: 64'h0123_4567_89AB_CDEF};
    for (int k = 0; k < OUTLEN; k++) sc[k*64 +: 64] = 64'(k * 100);
    sc[0 +: 64]    = 64'h7FFF_FFFF_FFFF_FFFF;
    sc[9*64 +: 64] = 64'h8000_0000_0000_0000;
    tbl[4] = '{scores: sc, exp_class: 8'd0, exp_max: 64'h7FFF_FFFF_FFFF_FFFF};
    for (int k = 0; k < OUTLEN; k++) sc[k*64 +: 64] = 64'd42;
    tbl[5] = '{scores: sc, exp_class: 8'd0, exp_max: 64'd42};

    rst_ni    = 1'b0;
    start_i   = 1'b0;
    ack_i     = 1'b0;
    scores_i  = '0;
    rd_addr_i = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // Idle after reset with no start.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      checkOutput($sformatf("idle busy %0d", i), 64'(busy_o), 64'd0);
      checkOutput($sformatf("idle done %0d", i), 64'(done_o), 64'd0);
    end
    checkOutput("idle class", 64'(class_o), 64'd0);
    checkOutput("idle max", max_score_o, 64'd0);
    checkReadback("idle", '0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      runAndCheck($sformatf("vec%0d", i), tbl[i].scores, tbl[i].exp_class, tbl[i].exp_max);
      ackResult($sformatf("vec%0d", i), tbl[i].exp_class, (i == 0) ? 5 : 1);
      checkReadback($sformatf("vec%0d", i), tbl[i].scores);
    end

    // Start during the scan, then start together with ack in DONE.
    for (int k = 0; k < OUTLEN; k++) begin
      sc_a[k*64 +: 64] = {$urandom, $urandom};
      sc_b[k*64 +: 64] = 64'h7FFF_FFFF_FFFF_FFFF - 64'(k);
    end
    refArgmax(sc_a, ec, em);
    @(negedge clk_i);
    scores_i = sc_a;
    start_i  = 1'b1;
    @(negedge clk_i);
    scores_i = sc_b;
    lat = 0;
    while (!done_o && lat < 40) begin
      start_i = (lat == 3);
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    checkOutput("restart latency", 64'(lat), 64'd9);
    checkOutput("restart class", 64'(class_o), 64'(ec));
    checkOutput("restart max", max_score_o, em);
    start_i = 1'b1;
    ack_i   = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    ack_i   = 1'b0;
    checkOutput("start+ack done", 64'(done_o), 64'd0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy_o || done_o) bad++;
      @(negedge clk_i);
    end
    checkOutput("no restart after start+ack", 64'(bad), 64'd0);
    checkOutput("start+ack class kept", 64'(class_o), 64'(ec));
    checkOutput("start+ack max kept", max_score_o, em);
    checkReadback("first vector kept", sc_a);

    // Asynchronous reset in the middle of a scan.
    for (int k = 0; k < OUTLEN; k++) sc[k*64 +: 64] = 64'(k * 3 + 1);
    sc[6*64 +: 64] = 64'd500;
    @(negedge clk_i);
    scores_i = sc;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async rst busy", 64'(busy_o), 64'd0);
    checkOutput("async rst done", 64'(done_o), 64'd0);
    checkOutput("async rst class", 64'(class_o), 64'd0);
    checkOutput("async rst max", max_score_o, 64'd0);
    checkOutput("async rst rd_data", 64'(rd_data_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) bad++;
    end
    checkOutput("no done after reset", 64'(bad), 64'd0);
    checkReadback("buffer cleared", '0);
    refArgmax(sc, ec, em);
    runAndCheck("post-reset", sc, ec, em);
    ackResult("post-reset", ec, 2);

    // Random vectors against the reference argmax.
    for (int n = 0; n < 30; n++) begin
      int     mode;
      int     sv;
      longint lv;
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < OUTLEN; k++) begin
        if (mode == 0) begin
          sc[k*64 +: 64] = {$urandom, $urandom};
        end else if (mode == 1) begin
          sv = int'($urandom_range(0, 6)) - 3;
          lv = sv;
          sc[k*64 +: 64] = lv;
        end else begin
          sc[k*64 +: 64] = 64'hFFFF_FFFF_0000_0000;
        end
      end
      if (mode == 2) sc[$urandom_range(0, OUTLEN - 1) * 64 +: 64] = {$urandom, $urandom};
      refArgmax(sc, ec, em);
      runAndCheck($sformatf("rand%0d", n), sc, ec, em);
      ackResult($sformatf("rand%0d", n), ec, int'($urandom_range(0, 3)));
      for (int j = 0; j < 3; j++) begin
        int a;
        a = int'($urandom_range(0, 31));
        @(negedge clk_i);
        rd_addr_i = ADDR_W'(a);
        @(negedge clk_i);
        checkOutput($sformatf("rand%0d rd[%0d]", n, a), 64'(rd_data_o), 64'(modelWord(sc, a)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
